// File: rtl/ball_motion_pkg.sv
// ball_motion_pkg: shared types and widths for the pong ball block.
//   ball_state_t : ball controller states (IDLE, SERVE, PLAY, SCORED)
//   X_POS_W/Y_POS_W : screen coordinate widths (640x480 fits in 10 bits)
//   BALL_SPEED_W : width of a per-frame speed magnitude
//   sprite_t     : sprite bundle handed to renderer/collision stage
package ball_motion_pkg;

  localparam int X_POS_W      = 10;
  localparam int Y_POS_W      = 10;
  localparam int BALL_SPEED_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    PLAY   = 2'd2,
    SCORED = 2'd3
  } ball_state_t;

  typedef struct packed {
    logic [X_POS_W-1:0] x_pos;
    logic [Y_POS_W-1:0] y_pos;
    logic [X_POS_W-1:0] right;
    logic [Y_POS_W-1:0] bottom;
  } sprite_t;

endpackage

// File: rtl/ball_motion_frame_delay_cnt.sv
// ball_motion_frame_delay_cnt: counts frame ticks while enabled.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous clear (held while not waiting for a serve)
//   tick_i        : qualified frame tick to count
//   done_o        : high in the cycle carrying the FRAMES-th tick
module ball_motion_frame_delay_cnt #(
  parameter int FRAMES = 60
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic tick_i,
  output logic done_o
);

  localparam int CNT_W = $clog2(FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAMES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Tick counter; saturates at LAST since the owner leaves SERVE on done
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (tick_i && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done_o = tick_i && (cnt_r == LAST);

endmodule

// File: rtl/ball_motion.sv
// ball_motion: per-frame pong ball physics (wall bounce, paddle reflect,
// scoring). Optional paddle speed-up is enabled by defining BALL_SPEEDUP_EN.
//   clk_i          : pixel clock
//   rst_ni         : async active-low reset
//   frame_tick_i   : 1-cycle pulse per frame
//   serve_i        : start request, honoured only in IDLE
//   coll_left_i    : ball/left-paddle overlap level
//   coll_right_i   : ball/right-paddle overlap level
//   ball_o         : sprite x_pos, y_pos, right, bottom
//   score_left_o   : 1-cycle pulse, left player scored
//   score_right_o  : 1-cycle pulse, right player scored
//   in_play_o      : high while in PLAY
module ball_motion
  import ball_motion_pkg::*;
#(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int SPEED_INIT   = 2,
  parameter int SPEED_MAX    = 6,
  parameter int SERVE_FRAMES = 60
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    frame_tick_i,
  input  logic    serve_i,
  input  logic    coll_left_i,
  input  logic    coll_right_i,
  output sprite_t ball_o,
  output logic    score_left_o,
  output logic    score_right_o,
  output logic    in_play_o
);

`ifdef BALL_SPEEDUP_EN
  localparam logic SPEEDUP = 1'b1;
`else
  localparam logic SPEEDUP = 1'b0;
`endif

  localparam logic [X_POS_W-1:0]        X_CTR    = X_POS_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [Y_POS_W-1:0]        Y_CTR    = Y_POS_W'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [X_POS_W-1:0]        X_BALL   = X_POS_W'(BALL_SIZE);
  localparam logic [Y_POS_W-1:0]        Y_BALL   = Y_POS_W'(BALL_SIZE);
  localparam logic signed [X_POS_W:0]   X_LIM    = (X_POS_W + 1)'(SCREEN_W - BALL_SIZE);
  localparam logic signed [Y_POS_W:0]   Y_LIM    = (Y_POS_W + 1)'(SCREEN_H - BALL_SIZE);
  localparam logic signed [Y_POS_W:0]   Y_STEP   = (Y_POS_W + 1)'(SPEED_INIT);
  localparam logic [BALL_SPEED_W-1:0]   SPD_INIT = BALL_SPEED_W'(SPEED_INIT);
  localparam logic [BALL_SPEED_W-1:0]   SPD_MAX  = BALL_SPEED_W'(SPEED_MAX);
  localparam logic [BALL_SPEED_W-1:0]   SPD_ONE  = BALL_SPEED_W'(1);

  ball_state_t               state_r, state_s;
  logic [X_POS_W-1:0]        x_r, x_s, right_r;
  logic [Y_POS_W-1:0]        y_r, y_s, bottom_r;
  logic                      dir_x_r, dir_x_s;   // 1 = moving right
  logic                      dir_y_r, dir_y_s;   // 1 = moving down
  logic [BALL_SPEED_W-1:0]   speed_x_r, speed_x_s;
  logic                      lat_left_r, lat_right_r;
  logic                      appl_l_s, appl_r_s, reflect_s;
  logic                      score_l_r, score_l_s, score_r_r, score_r_s;
  logic                      in_play_r;
  logic signed [X_POS_W:0]   x_step_s, x_wide_s;
  logic signed [Y_POS_W:0]   y_wide_s;
  logic                      serve_done_s, cnt_clr_s, cnt_tick_s;

  assign cnt_clr_s  = (state_r != SERVE);
  assign cnt_tick_s = frame_tick_i && (state_r == SERVE);

  ball_motion_frame_delay_cnt #(
    .FRAMES (SERVE_FRAMES)
  ) u_serve_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr_s),
    .tick_i (cnt_tick_s),
    .done_o (serve_done_s)
  );

  // Next-state and per-frame kinematics: reflect, step, wall bounce, score
  always_comb begin
    state_s   = state_r;
    x_s       = x_r;
    y_s       = y_r;
    dir_x_s   = dir_x_r;
    dir_y_s   = dir_y_r;
    speed_x_s = speed_x_r;
    score_l_s = 1'b0;
    score_r_s = 1'b0;
    reflect_s = 1'b0;
    // A collision seen in the tick cycle itself still counts
    appl_l_s  = lat_left_r | coll_left_i;
    appl_r_s  = lat_right_r | coll_right_i;
    x_step_s  = {(X_POS_W + 1){1'b0}};
    x_wide_s  = {(X_POS_W + 1){1'b0}};
    y_wide_s  = {(Y_POS_W + 1){1'b0}};
    case (state_r)
      IDLE: begin
        x_s = X_CTR;
        y_s = Y_CTR;
        if (serve_i) state_s = SERVE;
        else         state_s = IDLE;
      end
      SERVE: begin
        x_s = X_CTR;
        y_s = Y_CTR;
        if (serve_done_s) state_s = PLAY;
        else              state_s = SERVE;
      end
      PLAY: begin
        if (frame_tick_i) begin
          // Only a hit against the direction of travel reflects, so a
          // paddle overlapping for several frames flips the ball once.
          if (appl_l_s && !dir_x_r) begin
            dir_x_s   = 1'b1;
            reflect_s = 1'b1;
          end else if (appl_r_s && dir_x_r) begin
            dir_x_s   = 1'b0;
            reflect_s = 1'b1;
          end else begin
            dir_x_s   = dir_x_r;
            reflect_s = 1'b0;
          end
          if (SPEEDUP && reflect_s && (speed_x_r < SPD_MAX)) speed_x_s = speed_x_r + SPD_ONE;
          else                                                speed_x_s = speed_x_r;
          x_step_s = $signed({{(X_POS_W + 1 - BALL_SPEED_W){1'b0}}, speed_x_s});
          if (dir_x_s) x_wide_s = $signed({1'b0, x_r}) + x_step_s;
          else         x_wide_s = $signed({1'b0, x_r}) - x_step_s;
          if (dir_y_r) y_wide_s = $signed({1'b0, y_r}) + Y_STEP;
          else         y_wide_s = $signed({1'b0, y_r}) - Y_STEP;
          // Wall clamp: top is y<=0, bottom is y+BALL_SIZE>=SCREEN_H
          if (y_wide_s[Y_POS_W] || (y_wide_s == {(Y_POS_W + 1){1'b0}})) begin
            y_s     = {Y_POS_W{1'b0}};
            dir_y_s = 1'b1;
          end else if (y_wide_s >= Y_LIM) begin
            y_s     = Y_LIM[Y_POS_W-1:0];
            dir_y_s = 1'b0;
          end else begin
            y_s     = y_wide_s[Y_POS_W-1:0];
            dir_y_s = dir_y_r;
          end
          // Miss: serve next toward the player who lost the point
          if (x_wide_s[X_POS_W]) begin
            score_r_s = 1'b1;
            dir_x_s   = 1'b0;
            x_s       = X_CTR;
            y_s       = Y_CTR;
            speed_x_s = SPD_INIT;
            state_s   = SCORED;
          end else if (x_wide_s > X_LIM) begin
            score_l_s = 1'b1;
            dir_x_s   = 1'b1;
            x_s       = X_CTR;
            y_s       = Y_CTR;
            speed_x_s = SPD_INIT;
            state_s   = SCORED;
          end else begin
            x_s     = x_wide_s[X_POS_W-1:0];
            state_s = PLAY;
          end
        end else begin
          state_s = PLAY;
        end
      end
      SCORED: begin
        x_s     = X_CTR;
        y_s     = Y_CTR;
        state_s = SERVE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, ball kinematics and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      x_r       <= X_CTR;
      y_r       <= Y_CTR;
      right_r   <= X_CTR + X_BALL;
      bottom_r  <= Y_CTR + Y_BALL;
      dir_x_r   <= 1'b1;
      dir_y_r   <= 1'b1;
      speed_x_r <= SPD_INIT;
      score_l_r <= 1'b0;
      score_r_r <= 1'b0;
      in_play_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      x_r       <= x_s;
      y_r       <= y_s;
      right_r   <= x_s + X_BALL;
      bottom_r  <= y_s + Y_BALL;
      dir_x_r   <= dir_x_s;
      dir_y_r   <= dir_y_s;
      speed_x_r <= speed_x_s;
      score_l_r <= score_l_s;
      score_r_r <= score_r_s;
      in_play_r <= (state_s == PLAY);
    end
  end

  // Collision latches: accumulate between ticks, cleared at every tick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_left_r  <= 1'b0;
      lat_right_r <= 1'b0;
    end else if (frame_tick_i) begin
      lat_left_r  <= 1'b0;
      lat_right_r <= 1'b0;
    end else begin
      lat_left_r  <= lat_left_r | coll_left_i;
      lat_right_r <= lat_right_r | coll_right_i;
    end
  end

  assign ball_o.x_pos   = x_r;
  assign ball_o.y_pos   = y_r;
  assign ball_o.right   = right_r;
  assign ball_o.bottom  = bottom_r;
  assign score_left_o   = score_l_r;
  assign score_right_o  = score_r_r;
  assign in_play_o      = in_play_r;

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: randomized frames against a behavioural pong model;
// expected post-tick outputs are queued and checked by a separate monitor.
module tb_ball_motion;
  import ball_motion_pkg::*;

  localparam int W = 640, H = 480, BS = 8, SP0 = 2, SPMAX = 6, NSERVE = 60;
  localparam int CX = (W - BS) / 2, CY = (H - BS) / 2;
`ifdef BALL_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  typedef struct { int x; int y; bit sl; bit sr; bit ip; } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic frame_tick = 1'b0, serve = 1'b0, coll_l = 1'b0, coll_r = 1'b0;
  sprite_t ball;
  logic score_l, score_r, in_play;

  ball_motion dut (
    .clk_i(clk), .rst_ni(rst_n), .frame_tick_i(frame_tick), .serve_i(serve),
    .coll_left_i(coll_l), .coll_right_i(coll_r), .ball_o(ball),
    .score_left_o(score_l), .score_right_o(score_r), .in_play_o(in_play)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int n_checks = 0, n_errors = 0;
  bit end_req = 1'b0, end_done = 1'b0;

  // ---------------- reference model ----------------
  int m_phase;            // 0 waiting for serve, 1 serve delay, 2 play, 3 just scored
  int m_x, m_y, m_dx, m_dy, m_spd, m_cnt;
  bit m_ll, m_lr;

  task automatic model_reset();
    m_phase = 0; m_x = CX; m_y = CY; m_dx = 1; m_dy = 1; m_spd = SP0; m_cnt = 0;
    m_ll = 1'b0; m_lr = 1'b0;
  endtask

  task automatic model_cycle(input bit tick, input bit sv, input bit cl, input bit cr);
    bit al, ar, sl, sr, refl;
    exp_t e;
    al = m_ll | cl; ar = m_lr | cr; sl = 1'b0; sr = 1'b0; refl = 1'b0;
    if (tick) begin m_ll = 1'b0; m_lr = 1'b0; end
    else begin m_ll = al; m_lr = ar; end
    case (m_phase)
      0: if (sv) begin m_phase = 1; m_cnt = 0; end
      1: if (tick) begin
           m_cnt++;
           if (m_cnt == NSERVE) m_phase = 2;
         end
      2: if (tick) begin
           if (al && m_dx < 0) begin m_dx = 1; refl = 1'b1; end
           else if (ar && m_dx > 0) begin m_dx = -1; refl = 1'b1; end
           if (refl && SPEEDUP) m_spd = (m_spd + 1 > SPMAX) ? SPMAX : m_spd + 1;
           m_x = m_x + m_dx * m_spd;
           m_y = m_y + m_dy * SP0;
           if (m_y <= 0) begin m_y = 0; m_dy = 1; end
           else if (m_y + BS >= H) begin m_y = H - BS; m_dy = -1; end
           if (m_x < 0) begin sr = 1'b1; m_dx = -1; end
           else if (m_x + BS > W) begin sl = 1'b1; m_dx = 1; end
           if (sl || sr) begin m_x = CX; m_y = CY; m_spd = SP0; m_phase = 3; end
         end
      default: begin m_phase = 1; m_cnt = 0; end
    endcase
    if (tick) begin
      e.x = m_x; e.y = m_y; e.sl = sl; e.sr = sr; e.ip = (m_phase == 2);
      sb_q.push_back(e);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input bit tick, input bit sv, input bit cl, input bit cr);
    frame_tick = tick; serve = sv; coll_l = cl; coll_r = cr;
    model_cycle(tick, sv, cl, cr);
    @(posedge clk); #1;
  endtask

  // One frame: gap idle cycles then a tick; a collision lands on one random cycle
  task automatic run_frame(input bit cl, input bit cr, input bit sv);
    int gap, hit;
    gap = $urandom_range(4, 1);
    hit = $urandom_range(gap, 0);
    for (int i = 0; i <= gap; i++) drive(i == gap, sv && (i == 0), cl && (i == hit), cr && (i == hit));
  endtask

  // Collision level held for whole frames
  task automatic run_hold(input int frames, input bit cl, input bit cr);
    int gap;
    for (int f = 0; f < frames; f++) begin
      gap = $urandom_range(4, 1);
      for (int i = 0; i <= gap; i++) drive(i == gap, 1'b0, cl, cr);
    end
  endtask

  task automatic do_reset(input int cycles);
    frame_tick = 1'b0; serve = 1'b0; coll_l = 1'b0; coll_r = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit tick_q = 1'b0;
  exp_t last_e;

  always @(posedge clk) tick_q <= frame_tick && rst_n;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input bit pulses);
    check({tag, "_x"}, int'(ball.x_pos), e.x);
    check({tag, "_y"}, int'(ball.y_pos), e.y);
    check({tag, "_right"}, int'(ball.right), e.x + BS);
    check({tag, "_bottom"}, int'(ball.bottom), e.y + BS);
    check({tag, "_score_l"}, int'(score_l), pulses ? int'(e.sl) : 0);
    check({tag, "_score_r"}, int'(score_r), pulses ? int'(e.sr) : 0);
    check({tag, "_in_play"}, int'(in_play), int'(e.ip));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_e = '{x: CX, y: CY, sl: 1'b0, sr: 1'b0, ip: 1'b0};
      cmp("reset", last_e, 1'b0);
    end else if (tick_q) begin
      if (sb_q.size() == 0) check("sb_underflow", 0, 1);
      else begin
        last_e = sb_q.pop_front();
        cmp("tick", last_e, 1'b1);
      end
    end else begin
      cmp("hold", last_e, 1'b0);
    end
    if (end_req && !end_done) begin
      check("sb_drain", sb_q.size(), 0);
      end_done = 1'b1;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    do_reset(3);
    // No serve: ball parked at centre, no pulses
    for (int i = 0; i < 100; i++) run_frame(1'b0, 1'b0, 1'b0);
    // Serve, delay, then first moving frames
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NSERVE + 2; i++) run_frame(1'b0, 1'b0, 1'b0);
    // Five accepted paddle hits in a row
    for (int i = 0; i < 5; i++) run_frame(m_dx < 0, m_dx > 0, 1'b0);
    // Let the ball miss, re-serve and come back into play
    for (int k = 0; k < 400 && !(m_phase == 2 && m_x != CX); k++) run_frame(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 400 && m_phase != 2; k++) run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0);
    // Paddle overlap held across three frames on the facing side
    run_hold(3, m_dx < 0, m_dx > 0);
    // Randomized play, including ignored serves and wrong-side collisions
    for (int i = 0; i < 1500; i++)
      run_frame($urandom_range(9, 0) == 0, $urandom_range(9, 0) == 0, $urandom_range(19, 0) == 0);
    // Reset in the middle of play
    for (int k = 0; k < 400 && m_phase != 2; k++) run_frame(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) run_frame(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset(3);
    for (int i = 0; i < 5; i++) run_frame(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NSERVE + 20; i++) run_frame($urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    end_req = 1'b1;
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
